// File: rtl/sram_a_loader_if.sv
// Pixel stream into the SRAM A loader.
// Valid/ready handshake with an end-of-frame marker.
interface sram_a_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/sram_a_loader.sv
// Writes one raster-order input frame into the nine SRAM A banks
// using the 2x2-block, 3x3-interleaved word layout.
module sram_a_loader #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    start,
  sram_a_loader_if.slave          pix,
  output logic                    sram_write_enable_a0,
  output logic                    sram_write_enable_a1,
  output logic                    sram_write_enable_a2,
  output logic                    sram_write_enable_a3,
  output logic                    sram_write_enable_a4,
  output logic                    sram_write_enable_a5,
  output logic                    sram_write_enable_a6,
  output logic                    sram_write_enable_a7,
  output logic                    sram_write_enable_a8,
  output logic [3:0]              sram_bytemask_a,
  output logic [ADDR_WIDTH-1:0]   sram_waddr_a,
  output logic [4*DATA_WIDTH-1:0] sram_wdata_a,
  output logic                    busy,
  output logic                    load_done,
  output logic                    frame_err
);

  localparam int WPR = (IMG_W / 2 + 2) / 3;
  localparam int CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  c_odd, r_odd;
  logic [1:0]            bc_mod, br_mod;
  logic [ADDR_WIDTH-1:0] bc_div, row_base;

  logic       hs, col_end, row_end, last_px, clr;
  logic [3:0] bank;
  logic [1:0] lane;
  logic [8:0] we_n;

  assign pix.in_ready = (state == LOAD);
  assign hs      = pix.in_valid & pix.in_ready;
  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign last_px = col_end & row_end;
  assign clr     = (state == IDLE) & start;
  assign busy    = (state != IDLE);

  assign bank = ({2'b00, br_mod} * 4'd3) + {2'b00, bc_mod};
  assign lane = {r_odd, c_odd};

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (hs && last_px) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Block-row base advances by WPR every third block row.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      col      <= '0;
      row      <= '0;
      c_odd    <= 1'b0;
      r_odd    <= 1'b0;
      bc_mod   <= '0;
      br_mod   <= '0;
      bc_div   <= '0;
      row_base <= '0;
    end else if (hs) begin
      if (col_end) begin
        col    <= '0;
        c_odd  <= 1'b0;
        bc_mod <= '0;
        bc_div <= '0;
        row    <= row_end ? '0 : row + 1'b1;
        r_odd  <= ~r_odd;
        if (r_odd) begin
          if (br_mod == 2'd2) begin
            br_mod   <= '0;
            row_base <= row_base + ADDR_WIDTH'(WPR);
          end else begin
            br_mod <= br_mod + 1'b1;
          end
        end
      end else begin
        col   <= col + 1'b1;
        c_odd <= ~c_odd;
        if (c_odd) begin
          if (bc_mod == 2'd2) begin
            bc_mod <= '0;
            bc_div <= bc_div + 1'b1;
          end else begin
            bc_mod <= bc_mod + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      we_n            <= '1;
      sram_bytemask_a <= 4'hF;
      sram_waddr_a    <= '0;
      sram_wdata_a    <= '0;
      load_done       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      load_done <= (state == FLUSH);
      if (hs) begin
        we_n            <= ~(9'd1 << bank);
        sram_bytemask_a <= ~(4'd1 << lane);
        sram_waddr_a    <= row_base + bc_div;
        sram_wdata_a    <= {4{pix.in_data}};
      end else begin
        we_n            <= '1;
        sram_bytemask_a <= 4'hF;
      end
      if (clr)
        frame_err <= 1'b0;
      else if (hs && (pix.in_last != last_px))
        frame_err <= 1'b1;
    end
  end

  assign sram_write_enable_a0 = we_n[0];
  assign sram_write_enable_a1 = we_n[1];
  assign sram_write_enable_a2 = we_n[2];
  assign sram_write_enable_a3 = we_n[3];
  assign sram_write_enable_a4 = we_n[4];
  assign sram_write_enable_a5 = we_n[5];
  assign sram_write_enable_a6 = we_n[6];
  assign sram_write_enable_a7 = we_n[7];
  assign sram_write_enable_a8 = we_n[8];

endmodule

// File: tb/tb_sram_a_loader.sv
// Bench for sram_a_loader: scoreboard of expected writes,
// table of layout spot checks and multi-cycle corner cases.
module tb_sram_a_loader;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int NPIX = W * H;
  localparam int WPR  = (W / 2 + 2) / 3;
  localparam int NW   = ((H / 2 + 2) / 3) * WPR;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic start = 1'b0;
  logic we0, we1, we2, we3, we4, we5, we6, we7, we8;
  logic [3:0]    mask;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic busy, load_done, frame_err;

  sram_a_loader_if #(.DATA_WIDTH(DW)) pix ();

  sram_a_loader #(
    .IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .srst(srst), .start(start), .pix(pix),
    .sram_write_enable_a0(we0), .sram_write_enable_a1(we1),
    .sram_write_enable_a2(we2), .sram_write_enable_a3(we3),
    .sram_write_enable_a4(we4), .sram_write_enable_a5(we5),
    .sram_write_enable_a6(we6), .sram_write_enable_a7(we7),
    .sram_write_enable_a8(we8),
    .sram_bytemask_a(mask), .sram_waddr_a(waddr),
    .sram_wdata_a(wdata), .busy(busy),
    .load_done(load_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    int          addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          r;
    int          c;
    int          bank;
    int          addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } vec_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  ld_count = 0;
  int  wr_cnt = 0;
  bit  exp_err = 1'b0;

  logic [31:0] mem      [9][NW];
  logic [31:0] ref_img  [9][NW];
  logic [31:0] cont_img [9][NW];
  int          obs_bank [NPIX];
  int          obs_addr [NPIX];
  logic [3:0]  obs_mask [NPIX];
  logic [31:0] obs_data [NPIX];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix_val(input int idx);
    return (idx == 0) ? 8'hA5 : 8'(idx);
  endfunction

  function automatic wr_t model(input int idx);
    wr_t m;
    int r, c, br, bc, k;
    r  = idx / W;
    c  = idx % W;
    br = r / 2;
    bc = c / 2;
    k  = (r % 2) * 2 + (c % 2);
    m.bank    = (br % 3) * 3 + (bc % 3);
    m.addr    = (br / 3) * WPR + bc / 3;
    m.mask    = 4'hF;
    m.mask[k] = 1'b0;
    m.data    = {4{pix_val(idx)}};
    return m;
  endfunction

  always @(negedge clk) begin : mon
    logic [8:0] we;
    int nl, b;
    wr_t e;
    we = {we8, we7, we6, we5, we4, we3, we2, we1, we0};
    nl = 0;
    b  = 0;
    for (int i = 0; i < 9; i++)
      if (!we[i]) begin
        nl++;
        b = i;
      end
    if (nl == 1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(b), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("wr_bank", 32'(b), 32'(e.bank));
        chk("wr_addr", 32'(waddr), 32'(e.addr));
        chk("wr_mask", 32'(mask), 32'(e.mask));
        chk("wr_data", wdata, e.data);
      end
      if (wr_cnt < NPIX) begin
        obs_bank[wr_cnt] = b;
        obs_addr[wr_cnt] = int'(waddr);
        obs_mask[wr_cnt] = mask;
        obs_data[wr_cnt] = wdata;
      end
      wr_cnt++;
      if (int'(waddr) < NW)
        for (int k = 0; k < 4; k++)
          if (!mask[k]) mem[b][int'(waddr)][8*k +: 8] = wdata[8*k +: 8];
    end else if (nl > 1) begin
      chk("multi_enable", 32'(nl), 32'd1);
    end else if (!busy) begin
      chk("idle_mask", 32'(mask), 32'hF);
    end
    if (load_done) ld_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit last,
                       input bit st, input int idx, output bit acc);
    pix.in_valid = v;
    pix.in_data  = d;
    pix.in_last  = last;
    start        = st;
    @(negedge clk);
    chk("frame_err_cyc", 32'(frame_err), 32'(exp_err));
    acc = v && pix.in_ready;
    if (acc) q.push_back(model(idx));
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(pix.in_ready), 32'd0);
    chk({tag, "_we"}, 32'({we8, we7, we6, we5, we4, we3, we2, we1, we0}),
        32'h1FF);
    chk({tag, "_mask"}, 32'(mask), 32'hF);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    tick();
  endtask

  task automatic run_frame(input bit bubbles, input int err_at,
                           input bit drop_last, input int start_at,
                           input int abort_at);
    int idx, budget, ld0;
    bit v, last, acc, st_done;
    for (int b = 0; b < 9; b++)
      for (int a = 0; a < NW; a++) mem[b][a] = '0;
    wr_cnt  = 0;
    ld0     = ld_count;
    st_done = 1'b0;
    pix.in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("start_in_ready", 32'(pix.in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_frame_err", 32'(frame_err), 32'd0);
    tick();
    idx = 0;
    budget = 0;
    while (idx < NPIX && budget < 4 * NPIX) begin
      if (abort_at >= 0 && idx == abort_at) return;
      v    = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      last = (idx == err_at) || (idx == NPIX - 1 && !drop_last);
      drive(v, pix_val(idx), last, (idx == start_at) && !st_done, idx, acc);
      if (idx == start_at) st_done = 1'b1;
      if (acc) begin
        if (last != (idx == NPIX - 1)) exp_err = 1'b1;
        idx++;
      end
      budget++;
    end
    pix.in_valid = 1'b0;
    pix.in_last  = 1'b0;
    if (idx < NPIX) begin
      chk("frame_timeout", 32'(idx), 32'(NPIX));
      return;
    end
    @(negedge clk);
    chk("flush_in_ready", 32'(pix.in_ready), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_load_done", 32'(load_done), 32'd0);
    chk("flush_frame_err", 32'(frame_err), 32'(exp_err));
    tick();
    @(negedge clk);
    chk("done_load_done", 32'(load_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    chk("done_pulse_end", 32'(load_done), 32'd0);
    chk("done_count", 32'(ld_count), 32'(ld0 + 1));
    chk("writes_total", 32'(wr_cnt), 32'(NPIX));
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("idle_frame_err", 32'(frame_err), 32'(exp_err));
    tick();
  endtask

  task automatic check_image(input string tag, input bit vs_cont);
    for (int b = 0; b < 9; b++)
      for (int a = 0; a < NW; a++)
        chk(tag, mem[b][a], vs_cont ? cont_img[b][a] : ref_img[b][a]);
  endtask

  vec_t vt[8];

  initial begin
    wr_t m;
    int idx;
    pix.in_valid = 1'b0;
    pix.in_data  = '0;
    pix.in_last  = 1'b0;

    vt[0] = '{0, 0, 0, 0, 4'b1110, 32'hA5A5A5A5};
    vt[1] = '{0, 1, 0, 0, 4'b1101, 32'h01010101};
    vt[2] = '{1, 0, 0, 0, 4'b1011, 32'h20202020};
    vt[3] = '{0, 2, 1, 0, 4'b1110, 32'h02020202};
    vt[4] = '{0, 6, 0, 1, 4'b1110, 32'h06060606};
    vt[5] = '{2, 0, 3, 0, 4'b1110, 32'h40404040};
    vt[6] = '{6, 0, 0, 6, 4'b1110, 32'hC0C0C0C0};
    vt[7] = '{31, 31, 0, 35, 4'b0111, 32'hFFFFFFFF};

    for (int b = 0; b < 9; b++)
      for (int a = 0; a < NW; a++) ref_img[b][a] = '0;
    for (int i = 0; i < NPIX; i++) begin
      m = model(i);
      for (int k = 0; k < 4; k++)
        if (!m.mask[k]) ref_img[m.bank][m.addr][8*k +: 8] = pix_val(i);
    end

    repeat (3) tick();
    srst = 1'b0;
    check_reset_vals("reset");

    run_frame(1'b0, -1, 1'b0, -1, -1);
    for (int i = 0; i < 8; i++) begin
      idx = vt[i].r * W + vt[i].c;
      chk($sformatf("tbl%0d_bank", i), 32'(obs_bank[idx]), 32'(vt[i].bank));
      chk($sformatf("tbl%0d_addr", i), 32'(obs_addr[idx]), 32'(vt[i].addr));
      chk($sformatf("tbl%0d_mask", i), 32'(obs_mask[idx]), 32'(vt[i].mask));
      chk($sformatf("tbl%0d_data", i), obs_data[idx], vt[i].data);
    end
    check_image("image_cont", 1'b0);
    cont_img = mem;

    run_frame(1'b1, -1, 1'b0, -1, -1);
    check_image("image_bubble", 1'b1);

    run_frame(1'b0, 500, 1'b0, -1, -1);
    run_frame(1'b0, -1, 1'b1, -1, -1);

    srst  = 1'b1;
    start = 1'b1;
    tick();
    srst  = 1'b0;
    start = 1'b0;
    check_reset_vals("srst_start");

    run_frame(1'b0, -1, 1'b0, -1, 300);
    pix.in_valid = 1'b0;
    srst = 1'b1;
    idx = ld_count;
    @(negedge clk);
    tick();
    srst = 1'b0;
    check_reset_vals("abort");
    repeat (5) tick();
    chk("abort_no_done", 32'(ld_count), 32'(idx));
    chk("abort_queue", 32'(q.size()), 32'd0);
    chk("abort_writes", 32'(wr_cnt), 32'd300);

    run_frame(1'b0, -1, 1'b0, 100, -1);
    check_image("image_restart", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_a_loader.md
# sram_a_loader

Input-image loader that writes one LeNet input frame from a raster-order 8-bit pixel stream into the nine-bank SRAM A array. It sits on the write side of SRAM A and fills the banks in the 2x2-block, 3x3-interleaved layout that the convolution engine reads through `sram_raddr_a0..a8`. `load_done` drives the accelerator's `conv_start`. One pixel is accepted per cycle, and each accepted pixel produces one byte-masked SRAM write.

## Interface
- `IMG_W`, 32, image width in pixels (even, ≥2)
- `IMG_H`, 32, image height in pixels (even, ≥2)
- `DATA_WIDTH`, 8, pixel width
- `ADDR_WIDTH`, 10, SRAM A address width
- `clk`  in  1  clock; one clock domain, rising edge
- `srst`  in  1  synchronous active-high reset
- `start`  in  1  one-cycle pulse; begins a frame load
- `in_valid`  in  1  pixel valid
- `in_data`  in  DATA_WIDTH  pixel value
- `in_last`  in  1  asserted with the final pixel of the frame
- `in_ready`  out  1  loader accepts a pixel this cycle
- `sram_write_enable_a0..a8`  out  1 each  per-bank write enable, active-low
- `sram_bytemask_a`  out  4  byte mask, active-low; bit k enables lane k
- `sram_waddr_a`  out  ADDR_WIDTH  write address, shared by all banks
- `sram_wdata_a`  out  4*DATA_WIDTH  write data: the pixel replicated into all 4 lanes
- `busy`  out  1  high in LOAD and FLUSH
- `load_done`  out  1  one-cycle pulse after the final write
- `frame_err`  out  1  sticky; cleared by `start` or `srst`

## Operation
- Word layout: each 32-bit word holds one 2x2 pixel block.
  - For pixel (r,c), the lane is k = (r%2)*2 + (c%2), occupying bits [8k+7:8k].
- Block coordinates: br = r/2, bc = c/2.
- Bank = (br%3)*3 + (bc%3).
- Address = (br/3)*WPR + bc/3, where WPR = ceil((IMG_W/2)/3).
  - With the defaults, WPR = 6 and the maximum address is 35.
- Address generation uses incremental counters only (no dividers):
  - column c with sub-counters c%2, bc%3, bc/3;
  - row r with sub-counters r%2, br%3, br/3.
  - Column wraps at IMG_W-1, then the row increments.
- FSM states are IDLE, LOAD and FLUSH.
  - **IDLE:** `in_ready` = 0. `start` → LOAD, counters cleared, `frame_err` cleared.
  - **LOAD:** `in_ready` = 1. On each handshake, register one write and advance the counters. Accepting pixel (IMG_H-1, IMG_W-1) → FLUSH.
  - **FLUSH:** one cycle, `in_ready` = 0, then → IDLE with `load_done` pulsed.
- `start` while in LOAD or FLUSH is ignored.
- Frame check (sets `frame_err`; the load continues and still completes at the pixel count):
  - `in_last` = 1 on any pixel other than the final one;
  - `in_last` = 0 on the final pixel.
- Exactly one bank enable is low per write cycle. All enables are high otherwise, and the mask is 4'hF when idle.

## Timing
- Reset values:
  - `in_ready` 0, all `sram_write_enable_a*` 1, `sram_bytemask_a` 4'hF;
  - `sram_waddr_a` 0, `sram_wdata_a` 0;
  - `busy` 0, `load_done` 0, `frame_err` 0;
  - FSM in IDLE, all counters 0.
- `start` at cycle S: `in_ready` = 1 and `busy` = 1 from S+1.
- Handshake at cycle N (`in_valid` & `in_ready`): the registered write (enable, mask, address, data) is valid during N+1 for exactly one cycle.
- Back-to-back handshakes give back-to-back writes. A gap in `in_valid` gives a cycle with all enables high.
- Final pixel accepted at N:
  - N+1: FLUSH, final write visible, `in_ready` = 0.
  - N+2: IDLE, `load_done` = 1 for one cycle, `busy` = 0.
- `frame_err` rises at N+1 for an offending handshake at N.
- `srst` mid-load: all outputs return to reset values on the next edge, no further writes are issued, and no `load_done` is pulsed.
- `start` coincident with `srst`: reset wins.

## Test plan
- **Single pixels (default 32x32):**
  - Pixel (0,0) = 8'hA5 → bank 0 enable low, addr 0, mask 4'b1110, wdata 32'hA5A5A5A5.
  - Pixel (0,1) → bank 0, mask 4'b1101.
  - Pixel (1,0) → bank 0, mask 4'b1011.
- **Interleave:**
  - (0,2) → bank 1, addr 0.
  - (0,6) → bank 0, addr 1.
  - (2,0) → bank 3, addr 0.
  - (6,0) → bank 0, addr 6.
  - (31,31) → bank 0, addr 35, mask 4'b0111.
- **Full frame, continuous valid:**
  - 1024 pixels with value = index[7:0] → 1024 writes on consecutive cycles.
  - `load_done` two cycles after the last handshake.
  - Scoreboard memory image matches the layout formula.
  - `frame_err` = 0.
- **Bubbles:** random `in_valid` gaps → enables all high during gap cycles; final contents identical to the continuous-valid case.
- **Framing errors:**
  - `in_last` on pixel 500 → `frame_err` = 1 from the next cycle; the load still ends after 1024 pixels.
  - Next `start` clears `frame_err`.
  - Missing `in_last` on the final pixel → `frame_err` = 1.
- **Reset and ignored start:**
  - `srst` after 300 pixels → all outputs return to reset values; no `load_done`.
  - A new `start` loads correctly from (0,0).
  - `start` during LOAD → no counter change.
